// File: rtl/aes_cmd_issue.sv
// aes_cmd_issue: command FIFO plus single-outstanding issue FSM in front of the AES round controller.
// Optional watchdog on the WAIT state (adds err_o): define AES_ISSUE_TIMEOUT_EN.
package aes_pkg;
    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESKEYGENASSIST = 3'd3,
        AESDEC          = 3'd4,
        AESDECLAST      = 3'd5,
        AESIMC          = 3'd6,
        AESRSVD         = 3'd7
    } opcode;
endpackage

module aes_cmd_issue
    import aes_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  opcode        cmd_op_i,
    input  logic [127:0] cmd_state_i,
    input  logic [127:0] cmd_key_i,
    input  logic [7:0]   cmd_rcon_i,
    output logic         start_o,
    output opcode        opcode_o,
    output logic [127:0] state_o,
    output logic [127:0] key_o,
    output logic [7:0]   rcon_o,
    input  logic         cipher_ready_i,
    input  logic         key_ready_i,
    input  logic [127:0] result_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [127:0] res_data_o,
    output opcode        res_op_o,
    output logic         busy_o
`ifdef AES_ISSUE_TIMEOUT_EN
    ,
    output logic         err_o
`endif
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        opcode        op;
        logic [127:0] state;
        logic [127:0] key;
        logic [7:0]   rcon;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    fsm_q, fsm_d;
    cmd_t          cur_q, cur_d;
    logic [127:0]  res_data_q, res_data_d;
    opcode         res_op_q, res_op_d;

    logic op_legal;
    logic do_write;
    logic do_pop;
    logic done_hit;

    assign cmd_ready_o = (count_q != (PW+1)'(DEPTH));
    assign op_legal    = (cmd_op_i == AESENC) || (cmd_op_i == AESENCLAST) ||
                         (cmd_op_i == AESKEYGENASSIST);
    // Illegal opcodes complete the handshake but are dropped here.
    assign do_write    = cmd_valid_i && cmd_ready_o && op_legal;
    assign do_pop      = (fsm_q == ST_IDLE) && (count_q != '0);
    assign done_hit    = (cur_q.op == AESKEYGENASSIST) ? key_ready_i : cipher_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cur_d    = cur_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = '{op: cmd_op_i, state: cmd_state_i, key: cmd_key_i, rcon: cmd_rcon_i};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            cur_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_write, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef AES_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    assign err_o = err_q;
`endif

    always_comb begin
        fsm_d      = fsm_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
`ifdef AES_ISSUE_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
`endif
        case (fsm_q)
            ST_IDLE:  if (count_q != '0) fsm_d = ST_ISSUE;
            ST_ISSUE: begin
                fsm_d = ST_WAIT;
`ifdef AES_ISSUE_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
            ST_WAIT: begin
                if (done_hit) begin
                    res_data_d = result_i;
                    res_op_d   = cur_q.op;
                    fsm_d      = ST_RESP;
                end
`ifdef AES_ISSUE_TIMEOUT_EN
                // Give up silently after TIMEOUT_CYCLES WAIT cycles; only err_o records it.
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d = 1'b1;
                    fsm_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            ST_RESP:  if (res_ready_i) fsm_d = ST_IDLE;
            default:  fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fsm_q      <= ST_IDLE;
            cur_q      <= '0;
            res_data_q <= '0;
            res_op_q   <= NOOP;
`ifdef AES_ISSUE_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fsm_q      <= fsm_d;
            cur_q      <= cur_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
`ifdef AES_ISSUE_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign start_o     = (fsm_q == ST_ISSUE);
    assign res_valid_o = (fsm_q == ST_RESP);
    assign busy_o      = (fsm_q != ST_IDLE);
    assign opcode_o    = cur_q.op;
    assign state_o     = cur_q.state;
    assign key_o       = cur_q.key;
    assign rcon_o      = cur_q.rcon;
    assign res_data_o  = res_data_q;
    assign res_op_o    = res_op_q;

endmodule

// File: tb/tb_aes_cmd_issue.sv
// Bench for aes_cmd_issue: queue-based reference model compared every cycle under random
// traffic, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_aes_cmd_issue;
    import aes_pkg::*;

    localparam int DEPTH          = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic         clk = 1'b0;
    logic         nrst;
    logic         cmd_valid_i, cmd_ready_o;
    opcode        cmd_op_i;
    logic [127:0] cmd_state_i, cmd_key_i;
    logic [7:0]   cmd_rcon_i;
    logic         start_o;
    opcode        opcode_o;
    logic [127:0] state_o, key_o;
    logic [7:0]   rcon_o;
    logic         cipher_ready_i, key_ready_i;
    logic [127:0] result_i;
    logic         res_valid_o, res_ready_i;
    logic [127:0] res_data_o;
    opcode        res_op_o;
    logic         busy_o;
    logic         err_o;

    always #5 clk = ~clk;

    aes_cmd_issue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_state_i(cmd_state_i), .cmd_key_i(cmd_key_i), .cmd_rcon_i(cmd_rcon_i),
        .start_o(start_o), .opcode_o(opcode_o), .state_o(state_o), .key_o(key_o), .rcon_o(rcon_o),
        .cipher_ready_i(cipher_ready_i), .key_ready_i(key_ready_i), .result_i(result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_op_o(res_op_o), .busy_o(busy_o)
`ifdef AES_ISSUE_TIMEOUT_EN
        , .err_o(err_o)
`endif
    );

`ifndef AES_ISSUE_TIMEOUT_EN
    assign err_o = 1'b0;
`endif

    typedef struct {
        opcode        op;
        logic [127:0] st;
        logic [127:0] key;
        logic [7:0]   rcon;
    } cmd_s;

    // Reference model: phase 0 idle, 1 start cycle, 2 awaiting done, 3 offering response.
    cmd_s         m_q[$];
    int           m_phase  = 0;
    cmd_s         m_cur    = '{NOOP, 128'h0, 128'h0, 8'h0};
    logic [127:0] m_res    = '0;
    opcode        m_res_op = NOOP;
    int           m_waited = 0;
    logic         m_err    = 1'b0;

    int    n_cmp = 0;
    int    n_fail = 0;
    bit    auto_ctrl = 0;
    bit    gen_cmds = 0;
    bit    rr_always = 0;
    int    dly = 0;
    int    mon_starts = 0;
    int    mon_hs = 0;
    opcode hs_ops[$];

    function automatic bit isLegal(opcode op);
        return (op == AESENC) || (op == AESENCLAST) || (op == AESKEYGENASSIST);
    endfunction

    task automatic modelReset();
        m_q.delete();
        m_phase  = 0;
        m_cur    = '{NOOP, 128'h0, 128'h0, 8'h0};
        m_res    = '0;
        m_res_op = NOOP;
        m_waited = 0;
        m_err    = 1'b0;
    endtask

    task automatic modelStep();
        bit accept;
        bit done;
        accept = cmd_valid_i && (m_q.size() < DEPTH);
        case (m_phase)
            0: if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_phase = 1; end
            1: begin m_phase = 2; m_waited = 0; end
            2: begin
                done = (m_cur.op == AESKEYGENASSIST) ? key_ready_i : cipher_ready_i;
                if (done) begin
                    m_res = result_i; m_res_op = m_cur.op; m_phase = 3;
                end else begin
                    m_waited++;
`ifdef AES_ISSUE_TIMEOUT_EN
                    if (m_waited == TIMEOUT_CYCLES) begin m_err = 1'b1; m_phase = 0; end
`endif
                end
            end
            default: if (res_ready_i) m_phase = 0;
        endcase
        if (accept && isLegal(cmd_op_i))
            m_q.push_back('{cmd_op_i, cmd_state_i, cmd_key_i, cmd_rcon_i});
    endtask

    initial forever begin
        @(posedge clk or negedge nrst);
        if (!nrst) modelReset();
        else       modelStep();
    end

    task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("cmd_ready_o", cmd_ready_o, m_q.size() < DEPTH);
        checkOutput("start_o", start_o, m_phase == 1);
        checkOutput("busy_o", busy_o, m_phase != 0);
        checkOutput("res_valid_o", res_valid_o, m_phase == 3);
        checkOutput("opcode_o", opcode_o, m_cur.op);
        checkOutput("state_o", state_o, m_cur.st);
        checkOutput("key_o", key_o, m_cur.key);
        checkOutput("rcon_o", rcon_o, m_cur.rcon);
        checkOutput("res_data_o", res_data_o, m_res);
        checkOutput("res_op_o", res_op_o, m_res_op);
        checkOutput("err_o", err_o, m_err);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        compareAll();
    end

    task automatic applyStimulus();
        @(negedge clk);
        if (gen_cmds) begin
            cmd_valid_i = ($urandom_range(0, 1) == 1);
            cmd_op_i    = opcode'($urandom_range(0, 7));
            cmd_state_i = {$urandom, $urandom, $urandom, $urandom};
            cmd_key_i   = {$urandom, $urandom, $urandom, $urandom};
            cmd_rcon_i  = 8'($urandom);
        end
        if (auto_ctrl) begin
            result_i = {$urandom, $urandom, $urandom, $urandom};
            cipher_ready_i = ($urandom_range(0, 4) == 0);
            key_ready_i    = ($urandom_range(0, 4) == 0);
            if (m_phase == 2 && dly == 0) begin
                if (m_cur.op == AESKEYGENASSIST) key_ready_i = 1'b1;
                else                             cipher_ready_i = 1'b1;
            end
            if (m_phase != 2) dly = $urandom_range(0, 5);
            else if (dly > 0) dly--;
            res_ready_i = rr_always ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        if (start_o) mon_starts++;
        if (res_valid_o && res_ready_i) begin
            mon_hs++;
            hs_ops.push_back(res_op_o);
        end
    endtask

    task automatic quietCtrl();
        auto_ctrl = 0; cipher_ready_i = 0; key_ready_i = 0; result_i = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0, h0, k;
        logic [127:0] held;
        nrst = 1'b0; cmd_valid_i = 0; cmd_op_i = NOOP; cmd_state_i = '0; cmd_key_i = '0;
        cmd_rcon_i = '0; cipher_ready_i = 0; key_ready_i = 0; result_i = '0; res_ready_i = 0;
        repeat (3) applyStimulus();
        checkOutput("rst_cmd_ready", cmd_ready_o, 1'b1);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_opcode", opcode_o, NOOP);
        checkOutput("rst_res_op", res_op_o, NOOP);
        nrst = 1'b1;

        // Single AESENC: start at N+2, done 3 cycles after start, response the next cycle.
        applyStimulus();
        cmd_valid_i = 1; cmd_op_i = AESENC; cmd_rcon_i = 8'h00;
        cmd_state_i = 128'h00112233445566778899AABBCCDDEEFF;
        cmd_key_i   = 128'h0F0E0D0C0B0A09080706050403020100;
        applyStimulus(); cmd_valid_i = 0;
        checkOutput("t1_no_start_n1", start_o, 1'b0);
        applyStimulus();
        checkOutput("t1_start_n2", start_o, 1'b1);
        checkOutput("t1_opcode", opcode_o, AESENC);
        checkOutput("t1_state", state_o, 128'h00112233445566778899AABBCCDDEEFF);
        applyStimulus();
        checkOutput("t1_single_pulse", start_o, 1'b0);
        applyStimulus();
        applyStimulus();
        cipher_ready_i = 1; result_i = {16{8'hA5}};
        applyStimulus(); cipher_ready_i = 0; result_i = '0;
        checkOutput("t1_res_valid", res_valid_o, 1'b1);
        checkOutput("t1_res_data", res_data_o, {16{8'hA5}});
        checkOutput("t1_res_op", res_op_o, AESENC);
        res_ready_i = 1;
        applyStimulus(); res_ready_i = 0;
        checkOutput("t1_released", res_valid_o, 1'b0);

        // Five pushes with the controller stalled: FIFO fills, then drains in push order.
        res_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            cmd_valid_i = 1; cmd_op_i = (i % 2 == 1) ? AESENCLAST : AESENC;
            cmd_state_i = 128'(i + 1); cmd_key_i = 128'(i * 7);
        end
        applyStimulus(); cmd_valid_i = 0;
        checkOutput("t2_full", cmd_ready_o, 1'b0);
        applyStimulus(); cmd_valid_i = 1; cmd_op_i = AESENC;
        applyStimulus(); cmd_valid_i = 0;
        checkOutput("t2_still_full", cmd_ready_o, 1'b0);
        hs_ops.delete();
        auto_ctrl = 1; rr_always = 1;
        repeat (100) applyStimulus();
        checkOutput("t2_resp_count", hs_ops.size(), 5);
        for (int i = 0; i < 5 && i < hs_ops.size(); i++)
            checkOutput("t2_resp_order", hs_ops[i], (i % 2 == 1) ? AESENCLAST : AESENC);

        // AESKEYGENASSIST ignores cipher_ready_i and completes on key_ready_i.
        quietCtrl(); res_ready_i = 0;
        applyStimulus();
        cmd_valid_i = 1; cmd_op_i = AESKEYGENASSIST; cmd_rcon_i = 8'h36;
        cmd_state_i = 128'h1; cmd_key_i = 128'h2;
        applyStimulus(); cmd_valid_i = 0;
        applyStimulus();
        checkOutput("t3_start", start_o, 1'b1);
        checkOutput("t3_rcon", rcon_o, 8'h36);
        applyStimulus();
        cipher_ready_i = 1; result_i = 128'hDEADBEEF_00000000_11111111_22222222;
        applyStimulus(); cipher_ready_i = 0;
        checkOutput("t3_cipher_ignored", res_valid_o, 1'b0);
        applyStimulus();
        key_ready_i = 1; result_i = 128'hCAFEF00D_33333333_44444444_55555555;
        applyStimulus(); key_ready_i = 0; result_i = '0;
        checkOutput("t3_res_valid", res_valid_o, 1'b1);
        checkOutput("t3_res_data", res_data_o, 128'hCAFEF00D_33333333_44444444_55555555);
        checkOutput("t3_res_op", res_op_o, AESKEYGENASSIST);

        // Stall the response for 10 cycles with another command queued behind it.
        cmd_valid_i = 1; cmd_op_i = AESENCLAST; cmd_state_i = 128'h77; cmd_key_i = 128'h88;
        held = res_data_o;
        s0 = mon_starts;
        applyStimulus(); cmd_valid_i = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            checkOutput("t5_hold_valid", res_valid_o, 1'b1);
            checkOutput("t5_hold_data", res_data_o, held);
        end
        checkOutput("t5_no_start", mon_starts - s0, 0);
        res_ready_i = 1;
        applyStimulus(); res_ready_i = 0;
        k = 0;
        while (!(busy_o && !start_o && !res_valid_o) && k < 20) begin applyStimulus(); k++; end
        checkOutput("t5_reach_wait", busy_o && !start_o && !res_valid_o, 1'b1);
        #2 nrst = 1'b0;
        #1;
        checkOutput("t5_rst_busy", busy_o, 1'b0);
        checkOutput("t5_rst_ready", cmd_ready_o, 1'b1);
        checkOutput("t5_rst_opcode", opcode_o, NOOP);
        checkOutput("t5_rst_state", state_o, 128'h0);
        checkOutput("t5_rst_res_data", res_data_o, 128'h0);
        applyStimulus(); applyStimulus(); nrst = 1'b1;
        applyStimulus(); cipher_ready_i = 1; result_i = 128'h99;
        applyStimulus(); cipher_ready_i = 0;
        applyStimulus();
        checkOutput("t5_late_done_ignored", res_valid_o, 1'b0);
        checkOutput("t5_idle_after_rst", busy_o, 1'b0);

        // NOOP between two AESENCLAST: exactly two issues and two responses.
        auto_ctrl = 1; rr_always = 1;
        s0 = mon_starts; h0 = mon_hs;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            cmd_valid_i = 1; cmd_op_i = (i == 1) ? NOOP : AESENCLAST;
            cmd_state_i = 128'(100 + i);
        end
        applyStimulus(); cmd_valid_i = 0;
        repeat (60) applyStimulus();
        checkOutput("t4_starts", mon_starts - s0, 2);
        checkOutput("t4_responses", mon_hs - h0, 2);

`ifdef AES_ISSUE_TIMEOUT_EN
        // No done at all: error after TIMEOUT_CYCLES WAIT cycles, next command still issues.
        quietCtrl(); res_ready_i = 1;
        applyStimulus(); cmd_valid_i = 1; cmd_op_i = AESENC; cmd_state_i = 128'h5;
        applyStimulus(); cmd_op_i = AESENCLAST; cmd_state_i = 128'h6;
        applyStimulus(); cmd_valid_i = 0;
        repeat (16) applyStimulus();
        checkOutput("tmo_err_not_yet", err_o, 1'b0);
        applyStimulus();
        checkOutput("tmo_err_set", err_o, 1'b1);
        checkOutput("tmo_idle", busy_o, 1'b0);
        applyStimulus();
        checkOutput("tmo_next_start", start_o, 1'b1);
        checkOutput("tmo_next_op", opcode_o, AESENCLAST);
        auto_ctrl = 1;
        repeat (20) applyStimulus();
        checkOutput("tmo_err_sticky", err_o, 1'b1);
`endif

        // Random traffic, including illegal opcodes, spurious dones and one mid-run reset.
        auto_ctrl = 1; rr_always = 0; gen_cmds = 1;
        for (int i = 0; i < 800; i++) begin
            applyStimulus();
            if (i == 400) nrst = 1'b0;
            if (i == 402) nrst = 1'b1;
        end
        gen_cmds = 0; cmd_valid_i = 0; rr_always = 1;
        repeat (100) applyStimulus();
        checkOutput("drain_idle", busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
